imem_dual_responder: RTL

- Memory-side responder for the dual-slot fetch unit's instruction-memory interface.
- Serves two independent word reads per cycle with fixed 1-cycle latency, matching synchronous-BRAM timing.
- Contents are written sequentially by a valid/ready program-loader stream; reads are gated by a load FSM and per-word valid bits.
- Sits between the fetch stage and the boot/program loader.

---
 rtl/imem_dual_responder_if.sv | 39 +++
 rtl/imem_dual_responder.sv | 127 ++++++++++++
 2 files changed

// File: rtl/imem_dual_responder_if.sv
// Core-wide constants and the fetch/loader bus of imem_dual_responder.
// master: fetch unit + program loader side; slave: the memory responder.
package core_pkg;
    parameter int unsigned XLEN = 32;
endpackage

interface imem_dual_responder_if #(
    parameter int unsigned XLEN = core_pkg::XLEN
);
    // fetch read ports
    logic            imem_ren;
    logic [XLEN-1:0] imem_addr0;
    logic [XLEN-1:0] imem_addr1;
    logic [XLEN-1:0] imem_rdata0;
    logic [XLEN-1:0] imem_rdata1;
    logic            imem_err0;
    logic            imem_err1;
    // program loader stream
    logic            ld_start;
    logic            ld_valid;
    logic            ld_ready;
    logic [XLEN-1:0] ld_data;
    logic            ld_last;
    logic            load_done;

    modport master (
        output imem_ren, imem_addr0, imem_addr1,
        input  imem_rdata0, imem_rdata1, imem_err0, imem_err1,
        output ld_start, ld_valid, ld_data, ld_last,
        input  ld_ready, load_done
    );

    modport slave (
        input  imem_ren, imem_addr0, imem_addr1,
        output imem_rdata0, imem_rdata1, imem_err0, imem_err1,
        input  ld_start, ld_valid, ld_data, ld_last,
        output ld_ready, load_done
    );
endinterface

// File: rtl/imem_dual_responder.sv
// Dual-port instruction memory responder with 1-cycle read latency.
// Contents are written by a sequential valid/ready loader stream; reads return
// NOP_INSTR until a word has been loaded and the load has finished.
// Optional: define IMEM_ACCESS_CNT_EN to add the saturating access_cnt output.
module imem_dual_responder #(
    parameter int unsigned     XLEN      = core_pkg::XLEN,
    parameter int unsigned     DEPTH     = 16,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  reset,
    imem_dual_responder_if.slave  bus
`ifdef IMEM_ACCESS_CNT_EN
    ,
    output logic [31:0]           access_cnt
`endif
);
    localparam int unsigned     AW         = $clog2(DEPTH);
    localparam logic [AW-1:0]   PTR_LAST   = AW'(DEPTH - 1);
    localparam logic [XLEN-1:0] ADDR_LIMIT = XLEN'(DEPTH * 4);

    typedef enum logic {ST_LOAD, ST_READY} state_t;

    state_t          state;
    logic [AW-1:0]   ptr;
    logic [DEPTH-1:0] valid;
    logic            ld_ready_q;
    logic            load_done_q;

    logic [XLEN-1:0] mem [DEPTH];

    logic [AW-1:0]   idx0, idx1;
    logic            err0, err1;
    logic [XLEN-1:0] data0, data1;

    logic [XLEN-1:0] rdata0_q, rdata1_q;
    logic            err0_q, err1_q;

    // Load FSM: sequential writes in LOAD, ld_start in READY restarts the load
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_LOAD;
            ptr         <= '0;
            valid       <= '0;
            ld_ready_q  <= 1'b1;
            load_done_q <= 1'b0;
        end else begin
            unique case (state)
                ST_LOAD: begin
                    if (bus.ld_valid) begin
                        valid[ptr] <= 1'b1;
                        // The final accept leaves ptr alone so it can never wrap;
                        // the next load restarts it from 0 anyway.
                        if (bus.ld_last || ptr == PTR_LAST) begin
                            state       <= ST_READY;
                            ld_ready_q  <= 1'b0;
                            load_done_q <= 1'b1;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                ST_READY: begin
                    if (bus.ld_start) begin
                        state       <= ST_LOAD;
                        ptr         <= '0;
                        valid       <= '0;
                        ld_ready_q  <= 1'b1;
                        load_done_q <= 1'b0;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    // Memory array write from the loader; the array itself is never reset
    always_ff @(posedge clk) begin
        if (!reset && state == ST_LOAD && bus.ld_valid) begin
            mem[ptr] <= bus.ld_data;
        end
    end

    // Per-port address decode and read-data selection (reads see pre-write memory)
    always_comb begin
        idx0  = bus.imem_addr0[AW+1:2];
        idx1  = bus.imem_addr1[AW+1:2];
        err0  = (bus.imem_addr0[1:0] != 2'b00) || (bus.imem_addr0 >= ADDR_LIMIT);
        err1  = (bus.imem_addr1[1:0] != 2'b00) || (bus.imem_addr1 >= ADDR_LIMIT);
        data0 = (err0 || state == ST_LOAD || !valid[idx0]) ? NOP_INSTR : mem[idx0];
        data1 = (err1 || state == ST_LOAD || !valid[idx1]) ? NOP_INSTR : mem[idx1];
    end

    // Registered read responses; hold while imem_ren is low
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
        end else if (bus.imem_ren) begin
            rdata0_q <= data0;
            rdata1_q <= data1;
            err0_q   <= err0;
            err1_q   <= err1;
        end
    end

`ifdef IMEM_ACCESS_CNT_EN
    // Two reads per enabled READY cycle, saturating at all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            access_cnt <= '0;
        end else if (bus.imem_ren && state == ST_READY) begin
            access_cnt <= (access_cnt > 32'hFFFF_FFFD) ? '1 : access_cnt + 32'd2;
        end
    end
`endif

    assign bus.imem_rdata0 = rdata0_q;
    assign bus.imem_rdata1 = rdata1_q;
    assign bus.imem_err0   = err0_q;
    assign bus.imem_err1   = err1_q;
    assign bus.ld_ready    = ld_ready_q;
    assign bus.load_done   = load_done_q;

endmodule
